uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised second-generation UART receiver.
- Configurable data width, oversample ratio, one or two stop bits and parity.
- Input synchroniser and 3-sample majority voting on the line.
- Break detection, plus an on-chip receive FIFO that stores per-frame error flags and a sticky overrun flag.
- Sits between the UART pin and the host/bus interface; shares the system oversample tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
OVERSAMPLE, 16, oversample ticks per bit; power of two, 8..32
FIFO_DEPTH, 8, receive FIFO entries; power of two, >=2
SYNC_STAGES, 2, rx synchroniser flops; >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
oversample_tick  in  1  one-clk strobe, OVERSAMPLE per bit period
rx  in  1  asynchronous serial line, idle high
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  1 = two stop bits expected
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head
m_data  out  DATA_BITS  head data, LSB received first
m_parity_err  out  1  head frame parity error
m_frame_err  out  1  head frame stop-bit error
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
overrun  out  1  sticky: frame dropped because FIFO full
break_det  out  1  one-clk pulse on break condition
clear_err  in  1  clears overrun

Behaviour:
- Reset values: all registered outputs 0, FIFO empty, FSM IDLE, synchroniser flops 1.
- Synchroniser: rx passes through SYNC_STAGES flops to give rx_s. All FSM logic uses rx_s only.
- FSM advances only on oversample_tick. Sample counter width is $clog2(OVERSAMPLE).
- Majority vote:
  - Samples taken at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
  - Bit value = majority of the three samples.
  - Each bit period is OVERSAMPLE ticks.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
  - IDLE: rx_s==0 on a tick -> START, counter cleared. Latch parity_en, parity_odd and two_stop; changes mid-frame are ignored.
  - START: vote at mid-bit. Result 1 -> IDLE (false start, nothing pushed). Result 0 -> DATA.
  - DATA: DATA_BITS bits, shifted LSB-first. After the last bit -> PARITY if parity_en, else STOP1.
  - PARITY: expected = ^data ^ parity_odd. parity_err = (voted bit != expected).
  - STOP1: at the third vote sample, evaluate the stop bit.
    - If two_stop, continue to STOP2.
    - Otherwise end the frame and go to IDLE without waiting for the rest of the bit (resync margin).
  - STOP2: same evaluation as STOP1, then end the frame.
  - frame_err = any evaluated stop bit voted 0.
- Break:
  - Condition: all data bits 0, parity bit 0 (if enabled), and STOP1 voted 0.
  - Response: break_det pulses for one clk, nothing is pushed, FSM -> BREAK.
  - BREAK -> IDLE only after rx_s==1 on a tick.
- FIFO push:
  - At frame end, push {frame_err, parity_err, data} one clk after the deciding tick.
  - Frames with errors are still pushed.
- FIFO pop:
  - Show-ahead: m_valid = (fifo_count != 0); head fields are valid whenever m_valid=1.
  - Pop on m_valid & m_ready.
  - m_valid rises the clk after the push.
- Full FIFO:
  - Push when full with no pop the same clk: frame dropped, overrun <= 1.
  - Push when full with a pop the same clk: accepted, count unchanged.
  - Push and pop on an empty FIFO: push only (no pop, since m_valid was 0).
- Pointers wrap modulo FIFO_DEPTH.
- overrun clears on clear_err. A simultaneous set wins over clear.
- Reset mid-frame aborts the frame and empties the FIFO; no partial data is pushed.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 -> one entry m_data=0xA5, parity_err=0, frame_err=0, fifo_count=1. m_ready pulse -> count 0, m_valid=0.
- Odd parity enabled, send 0x3C with parity bit 0 (expected 1) -> m_data=0x3C, m_parity_err=1. Same frame with parity bit 1 -> m_parity_err=0.
- rx low for 3 oversample ticks only -> no push, FSM back in IDLE. A following 0x55 frame is received correctly.
- Single-tick glitch to 1 at mid-sample of bit 3 in 0x00 -> majority vote yields m_data=0x00, no error.
- FIFO_DEPTH=8, send 9 frames 0x01..0x09 without reads -> fifo_count=8, overrun=1, entries read out 0x01..0x08. clear_err -> overrun=0.
- two_stop=1, second stop bit driven 0 with data 0x7E -> m_frame_err=1, m_data=0x7E. rx held low for 2 frame times -> single break_det pulse, no push; release rx, send 0x33 -> received clean.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised, majority-voted line sampling, framing/parity
// checks, break detection and a show-ahead receive FIFO with error flags.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          oversample_tick,
    input  logic                          rx,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          clear_err
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;
    localparam int unsigned EW = DATA_BITS + 2;

    localparam logic [CW-1:0] SMP0  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP2  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CLAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL  = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Metastability guard on the asynchronous line; resets to idle-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ---------------- receive FSM ----------------
    state_t               state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [BW-1:0]        bit_q, bit_n;
    logic [DATA_BITS-1:0] sh_q, sh_n;
    logic                 s0_q, s0_n, s1_q, s1_n;
    logic                 pen_q, pen_n, podd_q, podd_n, two_q, two_n;
    logic                 pbit_q, pbit_n, perr_q, perr_n, ferr_q, ferr_n;
    logic                 push_q, push_n;
    logic [EW-1:0]        pdata_q, pdata_n;
    logic                 brk_n;
    logic                 vote;

    assign vote = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    // FSM and datapath register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            two_q     <= 1'b0;
            pbit_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            push_q    <= 1'b0;
            pdata_q   <= '0;
            break_det <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            sh_q      <= sh_n;
            s0_q      <= s0_n;
            s1_q      <= s1_n;
            pen_q     <= pen_n;
            podd_q    <= podd_n;
            two_q     <= two_n;
            pbit_q    <= pbit_n;
            perr_q    <= perr_n;
            ferr_q    <= ferr_n;
            push_q    <= push_n;
            pdata_q   <= pdata_n;
            break_det <= brk_n;
        end
    end

    // Next-state and frame decoding, advancing only on oversample ticks
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        s0_n    = s0_q;
        s1_n    = s1_q;
        pen_n   = pen_q;
        podd_n  = podd_q;
        two_n   = two_q;
        pbit_n  = pbit_q;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        push_n  = 1'b0;
        pdata_n = pdata_q;
        brk_n   = 1'b0;

        if (oversample_tick) begin
            if (state_q != IDLE && state_q != BREAK) begin
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == SMP0) s0_n = rx_s;
                if (cnt_q == SMP1) s1_n = rx_s;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                        bit_n   = '0;
                        pen_n   = parity_en;
                        podd_n  = parity_odd;
                        two_n   = two_stop;
                        pbit_n  = 1'b0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == SMP2 && vote) state_n = IDLE;
                    else if (cnt_q == CLAST)   state_n = DATA;
                end
                DATA: begin
                    if (cnt_q == SMP2) sh_n = {vote, sh_q[DATA_BITS-1:1]};
                    if (cnt_q == CLAST) begin
                        bit_n = bit_q + BW'(1);
                        if (bit_q == BLAST) begin
                            bit_n   = '0;
                            state_n = pen_q ? PARITY : STOP1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == SMP2) begin
                        pbit_n = vote;
                        perr_n = vote != (^sh_q ^ podd_q);
                    end
                    if (cnt_q == CLAST) state_n = STOP1;
                end
                STOP1: begin
                    if (cnt_q == SMP2) begin
                        if (!vote && sh_q == '0 && (!pen_q || !pbit_q)) begin
                            brk_n   = 1'b1;
                            state_n = BREAK;
                        end else begin
                            ferr_n = !vote;
                            if (!two_q) begin
                                // Leave mid-bit so the next start edge is caught early
                                push_n  = 1'b1;
                                pdata_n = {!vote, perr_q, sh_q};
                                state_n = IDLE;
                            end
                        end
                    end else if (cnt_q == CLAST && two_q) begin
                        state_n = STOP2;
                    end
                end
                STOP2: begin
                    if (cnt_q == SMP2) begin
                        ferr_n  = ferr_q | !vote;
                        push_n  = 1'b1;
                        pdata_n = {ferr_q | !vote, perr_q, sh_q};
                        state_n = IDLE;
                    end
                end
                BREAK: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [NW-1:0] count_n;
    logic [EW-1:0] head_n;
    logic          do_pop, do_push, ovr_set;

    // Push/pop arbitration and next head entry for the show-ahead outputs
    always_comb begin
        do_pop   = m_valid & m_ready;
        do_push  = push_q & ((fifo_count != FULL) | do_pop);
        ovr_set  = push_q & (fifo_count == FULL) & !do_pop;
        count_n  = fifo_count;
        if (do_push && !do_pop)      count_n = fifo_count + NW'(1);
        else if (!do_push && do_pop) count_n = fifo_count - NW'(1);
        rd_ptr_n = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        if (count_n == '0)                       head_n = '0;
        else if (do_push && wr_ptr == rd_ptr_n)  head_n = pdata_q;
        else                                     head_n = mem[rd_ptr_n];
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= pdata_q;
    end

    // Pointers, occupancy, registered head outputs and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_parity_err <= 1'b0;
            m_frame_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr       <= rd_ptr_n;
            fifo_count   <= count_n;
            m_valid      <= count_n != '0;
            m_data       <= head_n[DATA_BITS-1:0];
            m_parity_err <= head_n[DATA_BITS];
            m_frame_err  <= head_n[DATA_BITS+1];
            if (ovr_set)        overrun <= 1'b1;
            else if (clear_err) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a scoreboard of expected frames.
module tb_uart_rx_fifo;

    localparam int unsigned DB       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned FD       = 8;
    localparam int unsigned TICK_DIV = 4;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    logic                  clk        = 1'b0;
    logic                  reset      = 1'b1;
    logic                  oversample_tick = 1'b0;
    logic                  rx         = 1'b1;
    logic                  parity_en  = 1'b0;
    logic                  parity_odd = 1'b0;
    logic                  two_stop   = 1'b0;
    logic                  m_valid;
    logic                  m_ready    = 1'b0;
    logic [DB-1:0]         m_data;
    logic                  m_parity_err;
    logic                  m_frame_err;
    logic [$clog2(FD):0]   fifo_count;
    logic                  overrun;
    logic                  break_det;
    logic                  clear_err  = 1'b0;

    int   checks    = 0;
    int   errors    = 0;
    int   break_cnt = 0;
    int   div       = 0;
    exp_t sb[$];

    uart_rx_fifo #(
        .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .oversample_tick(oversample_tick), .rx(rx),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
        .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    // Oversample strobe, one clk every TICK_DIV clks
    always @(negedge clk) begin
        if (div == TICK_DIV - 1) begin
            div = 0;
            oversample_tick = 1'b1;
        end else begin
            div = div + 1;
            oversample_tick = 1'b0;
        end
    end

    // Count break pulses away from the active edge
    always @(negedge clk) begin
        if (break_det === 1'b1) break_cnt = break_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (oversample_tick !== 1'b1);
        #1;
    endtask

    task automatic hold_bit(input logic v, input int glitch_t);
        for (int t = 0; t < OS; t++) begin
            rx = (t == glitch_t) ? ~v : v;
            wait_tick();
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pen, input logic pbit,
                              input logic st1, input logic two, input logic st2,
                              input int glitch_bit);
        wait_tick();
        hold_bit(1'b0, -1);
        for (int i = 0; i < DB; i++) hold_bit(d[i], (glitch_bit == i) ? 9 : -1);
        if (pen) hold_bit(pbit, -1);
        hold_bit(st1, -1);
        if (two) hold_bit(st2, -1);
        rx = 1'b1;
        repeat (OS) wait_tick();
    endtask

    task automatic expect_frame(input logic [DB-1:0] d, input logic pen, input logic podd,
                                input logic pbit, input logic st1, input logic two,
                                input logic st2);
        exp_t e;
        e.data = d;
        e.perr = pen && (pbit != (^d ^ podd));
        e.ferr = !st1 || (two && !st2);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        int   n = 0;
        while (m_valid !== 1'b1 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (m_valid === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(m_data), 32'(e.data));
            check({tag, "_perr"}, 32'(m_parity_err), 32'(e.perr));
            check({tag, "_ferr"}, 32'(m_frame_err), 32'(e.ferr));
            @(negedge clk);
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_break", 32'(break_det), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) wait_tick();

        // 8N1 single frame
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        check("a5_count", 32'(fifo_count), 32'd1);
        pop_check("a5");
        check("a5_count_after", 32'(fifo_count), 32'd0);
        check("a5_valid_after", 32'(m_valid), 32'd0);

        // Odd parity, wrong then right parity bit
        parity_en = 1'b1;
        parity_odd = 1'b1;
        expect_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        pop_check("par_bad");
        expect_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        pop_check("par_good");
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // False start: low for three ticks only
        wait_tick();
        rx = 1'b0;
        repeat (3) wait_tick();
        rx = 1'b1;
        repeat (3 * OS) wait_tick();
        check("fs_count", 32'(fifo_count), 32'd0);
        check("fs_valid", 32'(m_valid), 32'd0);
        expect_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        pop_check("fs_55");

        // One-tick glitch at the mid sample of data bit 3
        expect_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        pop_check("glitch");

        // Overfill the FIFO by one frame
        for (int i = 1; i <= FD + 1; i++) begin
            if (i <= FD) expect_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        end
        check("full_count", 32'(fifo_count), 32'(FD));
        check("full_overrun", 32'(overrun), 32'd1);
        for (int i = 1; i <= FD; i++) pop_check("full_rd");
        check("drain_count", 32'(fifo_count), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("overrun_clear", 32'(overrun), 32'd0);

        // Two stop bits, second stop bit low
        two_stop = 1'b1;
        expect_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        pop_check("stop2_err");

        // Break: line low for two frame times
        repeat (2 * OS) wait_tick();
        break_cnt = 0;
        wait_tick();
        rx = 1'b0;
        repeat (2 * 12 * OS) wait_tick();
        check("break_pulses", 32'(break_cnt), 32'd1);
        check("break_nopush", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        repeat (2 * OS) wait_tick();
        check("break_pulses_after", 32'(break_cnt), 32'd1);
        expect_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        pop_check("post_break");
        check("final_count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
